mul_hilo_ctrl: RTL

- Sequences the pipelined 33×33 multiplier for MULT/MULTU and owns the architectural HI/LO registers.
- Serves MTHI/MTLO/MFHI/MFLO requests from the EX stage and stalls the pipeline while a multiply is in flight.
- Supports cancellation of an in-flight multiply on an exception flush.
- Sits between the EX stage and the multiplier instance inside the 5-stage CPU.

---
 rtl/mul_hilo_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mul_hilo_ctrl.sv
// Sequences the multiplier for MULT/MULTU and owns the architectural HI/LO registers.
// Latency: a multiply holds the controller for MUL_LAT+2 cycles; MT* takes 1 cycle; MF* returns data in the same cycle.
// Backpressure: req_ready drops while a multiply is in flight, and EX holds its request until req_ready rises.
//
// Optional feature macro: MUL_BYPASS_EN. When it is defined, an MFHI/MFLO request is
// accepted in the final BUSY cycle, and its data comes straight from mul_result.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   flush             cancels an in-flight multiply and discards this cycle's request
//   req_valid/req_op/req_a/req_b/req_ready   EX-stage request handshake
//   mf_valid/mf_data  MFHI/MFLO result, valid in the accept cycle
//   mul_x/mul_y/mul_signed/mul_clken/mul_result   external pipelined multiplier
//   hi, lo            architectural HI/LO
module mul_hilo_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  output logic        mf_valid,
  output logic [31:0] mf_data,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  output logic        mul_signed,
  output logic        mul_clken,
  input  logic [63:0] mul_result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd3;
  localparam logic [2:0] OP_MTLO  = 3'd4;
  localparam logic [2:0] OP_MFHI  = 3'd5;
  localparam logic [2:0] OP_MFLO  = 3'd6;

  // The counter is 4 bits wide so that it can hold MUL_LAT+1, which is up to 9 at MUL_LAT=8.
  localparam int         CW       = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_mf;
  logic          accept;
  logic [63:0]   mf_src;

  assign is_mf = (req_op == OP_MFHI) || (req_op == OP_MFLO);

`ifdef MUL_BYPASS_EN
  logic bypass_win;
  // During the last BUSY cycle the product is already on mul_result, so MF* can read it from there.
  assign bypass_win = (state == BUSY) && (cnt == CNT_ONE);
  assign req_ready  = rst || (state == IDLE) || (bypass_win && is_mf);
  assign mf_src     = bypass_win ? mul_result : {hi, lo};
`else
  assign req_ready  = rst || (state == IDLE);
  assign mf_src     = {hi, lo};
`endif

  // A request seen during reset or flush is discarded, even when req_ready is high.
  assign accept    = req_valid && req_ready && !rst && !flush;
  assign mf_valid  = accept && is_mf;
  assign mul_clken = (state == BUSY) && !rst;

  always_comb begin
    mf_data = 32'd0;
    if (mf_valid) begin
      mf_data = (req_op == OP_MFHI) ? mf_src[63:32] : mf_src[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      mul_x      <= 32'd0;
      mul_y      <= 32'd0;
      mul_signed <= 1'b0;
    end else if (flush) begin
      // A cancelled multiply never writes HI/LO. The multiplier pipe simply idles.
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (req_op)
              OP_MULT, OP_MULTU: begin
                mul_x      <= req_a;
                mul_y      <= req_b;
                mul_signed <= (req_op == OP_MULT);
                cnt        <= CNT_INIT;
                state      <= BUSY;
              end
              OP_MTHI: hi <= req_a;
              OP_MTLO: lo <= req_a;
              default: ;
            endcase
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            hi    <= mul_result[63:32];
            lo    <= mul_result[31:0];
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
